corr_chunk_sched: RTL and testbench

- Sequences the 8-lane complex multiply-accumulate stage (stage_mult) so one NUM_CHUNKS×8-tap complex correlation (default 64 taps) runs as NUM_CHUNKS back-to-back 8-sample chunks.
- Issues chunk reads to the paired sample/coefficient buffer and generates the stage's input strobe.
- Collects the stage's per-chunk 64-bit sums and accumulates them into one wide I/Q result.
- Sits between the preamble detector, which requests correlations at a base address, and the long-preamble sync logic, which consumes the result.

---
 rtl/corr_chunk_sched_pkg.sv | 20 ++
 rtl/corr_chunk_sched_if.sv | 33 +++
 rtl/corr_chunk_sched_acc.sv | 44 ++++
 rtl/corr_chunk_sched.sv | 153 +++++++++++++++
 tb/tb_corr_chunk_sched.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/corr_chunk_sched_pkg.sv
// Shared encodings for the chunked correlation scheduler: FSM states,
// field positions in the 64-bit stage sum word, and the default stage latency.
package corr_chunk_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SUM_I_MSB = 63;
    localparam int SUM_I_LSB = 32;
    localparam int SUM_Q_MSB = 31;
    localparam int SUM_Q_LSB = 0;

    // rd_en to stage output strobe: one buffer read cycle plus five stage cycles
    localparam int MULT_LAT_DEF = 6;

endpackage

// File: rtl/corr_chunk_sched_if.sv
// Bundle between the scheduler, its requester, the sample/coeff buffer,
// the stage_mult lanes and the result consumer.
interface corr_chunk_sched_if #(
    parameter int ADDR_W = 8,
    parameter int ACC_W  = 36
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              start_drop;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              mult_strobe;
    logic [63:0]       mult_sum;
    logic              mult_sum_strobe;
    logic [ACC_W-1:0]  corr_i;
    logic [ACC_W-1:0]  corr_q;
    logic              corr_strobe;
    logic              timeout_err;

    modport master (
        input  start, base_addr, mult_sum, mult_sum_strobe,
        output busy, start_drop, rd_en, rd_addr, mult_strobe,
               corr_i, corr_q, corr_strobe, timeout_err
    );

    modport slave (
        output start, base_addr, mult_sum, mult_sum_strobe,
        input  busy, start_drop, rd_en, rd_addr, mult_strobe,
               corr_i, corr_q, corr_strobe, timeout_err
    );

endinterface

// File: rtl/corr_chunk_sched_acc.sv
// Signed dual I/Q accumulator: sign-extends the two 32-bit halves of a
// stage sum word and adds them into ACC_W-bit running totals.
module corr_acc
    import corr_chunk_sched_pkg::*;
#(
    parameter int ACC_W = 36
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_clr,
    input  logic                    i_add,
    input  logic [63:0]             i_sum,
    output logic signed [ACC_W-1:0] o_acc_i,
    output logic signed [ACC_W-1:0] o_acc_q
);

    logic signed [ACC_W-1:0] r_acc_i;
    logic signed [ACC_W-1:0] r_acc_q;
    logic signed [ACC_W-1:0] w_ext_i;
    logic signed [ACC_W-1:0] w_ext_q;

    assign w_ext_i = ACC_W'($signed(i_sum[SUM_I_MSB:SUM_I_LSB]));
    assign w_ext_q = ACC_W'($signed(i_sum[SUM_Q_MSB:SUM_Q_LSB]));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_acc_i <= '0;
                r_acc_q <= '0;
            end else if (i_add) begin
                r_acc_i <= r_acc_i + w_ext_i;
                r_acc_q <= r_acc_q + w_ext_q;
            end
        end
    end

    assign o_acc_i = r_acc_i;
    assign o_acc_q = r_acc_q;

endmodule

// File: rtl/corr_chunk_sched.sv
// Runs one NUM_CHUNKS x 8-tap complex correlation as back-to-back chunk reads
// through stage_mult, accumulating the per-chunk sums into one I/Q result.
module corr_chunk_sched
    import corr_chunk_sched_pkg::*;
#(
    parameter int NUM_CHUNKS    = 8,
    parameter int ADDR_W        = 8,
    parameter int ACC_W         = 36,
    parameter int MULT_LAT      = MULT_LAT_DEF,
    parameter int TIMEOUT_SLACK = 4
) (
    input logic                i_clk,
    input logic                i_rst_n,
    input logic                i_enable,
    corr_chunk_sched_if.master io_bus
);

    localparam int LIMIT = NUM_CHUNKS + MULT_LAT + TIMEOUT_SLACK;
    localparam int IC_W  = $clog2(NUM_CHUNKS);
    localparam int RC_W  = $clog2(NUM_CHUNKS + 1);
    localparam int TO_W  = $clog2(LIMIT + 1);

    localparam logic [IC_W-1:0] LAST_ISSUE = IC_W'(NUM_CHUNKS - 1);
    localparam logic [RC_W-1:0] RC_FULL    = RC_W'(NUM_CHUNKS);
    localparam logic [RC_W-1:0] RC_LAST    = RC_W'(NUM_CHUNKS - 1);
    localparam logic [TO_W-1:0] TO_HIT     = TO_W'(LIMIT - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_W-1:0]       r_addr;
    logic [IC_W-1:0]         r_issue_cnt;
    logic [RC_W-1:0]         r_rcv_cnt;
    logic [TO_W-1:0]         r_to_cnt;
    logic                    r_mult_strobe;
    logic                    r_corr_strobe;
    logic                    r_timeout;
    logic                    r_start_drop;
    logic [ACC_W-1:0]        r_corr_i;
    logic [ACC_W-1:0]        r_corr_q;

    logic                    w_busy;
    logic                    w_rd_en;
    logic                    w_accept;
    logic                    w_take;
    logic                    w_full;
    logic                    w_last_issue;
    logic                    w_to_hit;
    logic                    w_timeout;
    logic signed [ACC_W-1:0] w_acc_i;
    logic signed [ACC_W-1:0] w_acc_q;

    assign w_busy       = (r_state != ST_IDLE);
    assign w_rd_en      = (r_state == ST_ISSUE);
    assign w_accept     = (r_state == ST_IDLE) && io_bus.start;
    assign w_take       = ((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) &&
                          io_bus.mult_sum_strobe && (r_rcv_cnt != RC_FULL);
    assign w_full       = (r_rcv_cnt == RC_FULL) || (w_take && (r_rcv_cnt == RC_LAST));
    assign w_last_issue = (r_issue_cnt == LAST_ISSUE);
    assign w_to_hit     = (r_to_cnt == TO_HIT);

    // Completion may arrive mid-ISSUE with a short stage; issues still finish first.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.start) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_last_issue && w_full) begin
                    w_state_nxt = ST_DONE;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end else if (w_last_issue) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_full) begin
                    w_state_nxt = ST_DONE;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_issue_cnt   <= '0;
            r_rcv_cnt     <= '0;
            r_to_cnt      <= '0;
            r_mult_strobe <= 1'b0;
            r_corr_strobe <= 1'b0;
            r_timeout     <= 1'b0;
            r_start_drop  <= 1'b0;
            r_corr_i      <= '0;
            r_corr_q      <= '0;
        end else if (i_enable) begin
            r_state       <= w_state_nxt;
            r_mult_strobe <= w_rd_en;
            r_corr_strobe <= (r_state == ST_DONE);
            r_timeout     <= w_timeout;
            r_start_drop  <= w_busy && io_bus.start;
            // Timeout count includes the start cycle itself.
            if (w_accept) begin
                r_addr      <= io_bus.base_addr;
                r_issue_cnt <= '0;
                r_rcv_cnt   <= '0;
                r_to_cnt    <= TO_W'(1);
            end else begin
                if (w_rd_en) begin
                    r_addr      <= r_addr + 1'b1;
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                end
                if (w_take) r_rcv_cnt <= r_rcv_cnt + 1'b1;
                if (w_busy) r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (r_state == ST_DONE) begin
                r_corr_i <= w_acc_i;
                r_corr_q <= w_acc_q;
            end
        end
    end

    corr_acc #(.ACC_W(ACC_W)) u_acc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_enable),
        .i_clr   (w_accept),
        .i_add   (w_take),
        .i_sum   (io_bus.mult_sum),
        .o_acc_i (w_acc_i),
        .o_acc_q (w_acc_q)
    );

    assign io_bus.busy        = w_busy;
    assign io_bus.start_drop  = r_start_drop;
    assign io_bus.rd_en       = w_rd_en;
    assign io_bus.rd_addr     = r_addr;
    assign io_bus.mult_strobe = r_mult_strobe;
    assign io_bus.corr_i      = r_corr_i;
    assign io_bus.corr_q      = r_corr_q;
    assign io_bus.corr_strobe = r_corr_strobe;
    assign io_bus.timeout_err = r_timeout;

endmodule

// File: tb/tb_corr_chunk_sched.sv
// Directed bench for corr_chunk_sched with a behavioural stage_mult model
// and address/result/timeout scoreboards.
module tb_corr_chunk_sched;

    localparam int N     = 8;
    localparam int ACC_W = 36;

    typedef struct {
        logic [ACC_W-1:0] ci;
        logic [ACC_W-1:0] cq;
        int               at;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [7:0] q_addr[$];
    res_t       q_res[$];
    int         q_to[$];

    logic [ACC_W-1:0] last_i = '0;
    logic [ACC_W-1:0] last_q = '0;
    logic [5:0]       sr = '0;
    int               sent = 0;
    int               allowed = 0;
    logic             exp_ms;

    corr_chunk_sched_if #(.ADDR_W(8), .ACC_W(ACC_W)) bus ();

    corr_chunk_sched #(
        .NUM_CHUNKS   (N),
        .ADDR_W       (8),
        .ACC_W        (ACC_W),
        .MULT_LAT     (6),
        .TIMEOUT_SLACK(4)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_enable (en),
        .io_bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // stage_mult model: 6 enabled cycles from rd_en to sum strobe, frozen by enable
    always @(posedge clk) begin
        if (en) begin
            if (bus.rd_en && sent < allowed) begin
                sr   <= {sr[4:0], 1'b1};
                sent <= sent + 1;
            end else begin
                sr <= {sr[4:0], 1'b0};
            end
        end
    end
    assign bus.mult_sum_strobe = sr[5];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)  exp_ms <= 1'b0;
        else if (en) exp_ms <= bus.rd_en;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] mul_ext(input int n, input logic [31:0] v);
        longint s;
        s = longint'($signed(v)) * longint'(n);
        return s[ACC_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},   64'(bus.busy), 64'd0);
        check({tag, "_rd_en"},  64'(bus.rd_en), 64'd0);
        check({tag, "_rdaddr"}, 64'(bus.rd_addr), 64'd0);
        check({tag, "_mstrb"},  64'(bus.mult_strobe), 64'd0);
        check({tag, "_corr_i"}, 64'(bus.corr_i), 64'd0);
        check({tag, "_corr_q"}, 64'(bus.corr_q), 64'd0);
        check({tag, "_cstrb"},  64'(bus.corr_strobe), 64'd0);
        check({tag, "_tmo"},    64'(bus.timeout_err), 64'd0);
        check({tag, "_drop"},   64'(bus.start_drop), 64'd0);
    endtask

    // Called in the cycle start is presented; returns in the cycle after.
    task automatic do_start(input logic [7:0] base, input logic [31:0] si, input logic [31:0] sq,
                            input int nstr, input int lat, input bit expect_to);
        res_t r;
        logic [7:0] a;
        int c0;
        c0 = cyc;
        bus.mult_sum = {si, sq};
        allowed = sent + nstr;
        for (int k = 0; k < N; k++) begin
            a = base + 8'(k);
            q_addr.push_back(a);
        end
        if (expect_to) begin
            q_to.push_back(c0 + 18);
        end else begin
            r.ci = mul_ext(nstr, si);
            r.cq = mul_ext(nstr, sq);
            r.at = c0 + lat;
            q_res.push_back(r);
        end
        bus.base_addr = base;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("mult_strobe", 64'(bus.mult_strobe), 64'(exp_ms));
            if (en && bus.rd_en) begin
                if (q_addr.size() == 0) begin
                    check("rd_en_unexpected", 64'(bus.rd_en), 64'd0);
                end else begin
                    check("rd_addr", 64'(bus.rd_addr), 64'(q_addr.pop_front()));
                end
            end
            if (bus.corr_strobe) begin
                if (q_res.size() == 0) begin
                    check("corr_strobe_unexpected", 64'(bus.corr_strobe), 64'd0);
                end else begin
                    res_t e;
                    e = q_res.pop_front();
                    check("corr_cycle", 64'(cyc), 64'(e.at));
                    check("corr_i", 64'(bus.corr_i), 64'(e.ci));
                    check("corr_q", 64'(bus.corr_q), 64'(e.cq));
                    check("busy_at_result", 64'(bus.busy), 64'd0);
                    last_i = e.ci;
                    last_q = e.cq;
                end
            end
            if (bus.timeout_err) begin
                if (q_to.size() == 0) begin
                    check("timeout_unexpected", 64'(bus.timeout_err), 64'd0);
                end else begin
                    check("timeout_cycle", 64'(cyc), 64'(q_to.pop_front()));
                    check("busy_at_timeout", 64'(bus.busy), 64'd0);
                    check("corr_i_kept", 64'(bus.corr_i), 64'(last_i));
                    check("corr_q_kept", 64'(bus.corr_q), 64'(last_q));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.mult_sum = '0;
        #1;
        check_zero_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // nominal
        do_start(8'h10, 32'd1000, 32'hFFFF_FE0C, N, 16, 1'b0);
        check("busy_after_start", 64'(bus.busy), 64'd1);
        repeat (20) tick();

        // address wrap and sign extension
        do_start(8'hFE, 32'h8000_0000, 32'h7FFF_FFFF, N, 16, 1'b0);
        repeat (20) tick();

        // collisions, then back-to-back
        do_start(8'h20, 32'hFFFF_FFF9, 32'd300000, N, 16, 1'b0);
        repeat (4) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_drop_pulse", 64'(bus.start_drop), 64'd1);
        tick();
        check("start_drop_clear", 64'(bus.start_drop), 64'd0);
        repeat (8) tick();
        bus.start = 1'b1;
        check("busy_in_done", 64'(bus.busy), 64'd1);
        tick();
        check("start_drop_done", 64'(bus.start_drop), 64'd1);
        do_start(8'h40, 32'd123456, 32'hFFF0_0000, N, 16, 1'b0);
        check("start_drop_b2b", 64'(bus.start_drop), 64'd0);
        repeat (20) tick();

        // timeout with one strobe missing
        do_start(8'h60, 32'd5, 32'd5, N - 1, 0, 1'b1);
        repeat (22) tick();
        check("busy_after_timeout", 64'(bus.busy), 64'd0);

        // stall mid-ISSUE
        do_start(8'h80, 32'h0001_2345, 32'hFFFF_0000, N, 19, 1'b0);
        tick();
        tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (22) tick();

        // reset during DRAIN
        do_start(8'h30, 32'd1000, 32'd2000, N, 16, 1'b0);
        repeat (10) tick();
        rst_n = 1'b0;
        q_res.delete();
        last_i = '0;
        last_q = '0;
        #1;
        check_zero_outputs("midreset");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        do_start(8'h50, 32'd7, 32'hFFFF_FFFD, N, 16, 1'b0);
        repeat (20) tick();

        check("addr_queue_left", 64'(q_addr.size()), 64'd0);
        check("res_queue_left", 64'(q_res.size()), 64'd0);
        check("to_queue_left", 64'(q_to.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
